dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the core's data port (d_addr/d_data/d_rd/d_we byte-lane interface); the target side of the core's load/store traffic.
- Holds a word-organised RAM with byte-lane writes.
- Stores are posted and complete in one cycle.
- Loads pass through a small FSM with a configurable number of wait states, then return lane-masked data with a one-cycle valid pulse.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, ≥4.
- READ_LAT, 1, cycles from read acceptance to d_valid_o; ≥1.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH_WORDS*4.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- d_addr_i  in  32  byte address from core; bits [1:0] ignored.
- d_data_i  in  32  store data from core.
- d_rd_i  in  4  byte-lane read strobes; nonzero = read request.
- d_we_i  in  4  byte-lane write enables; nonzero = write request.
- d_data_o  out  32  load data to core.
- d_valid_o  out  1  one-cycle pulse; d_data_o is valid in that cycle.
- d_busy_o  out  1  high in WAIT and RESP.
- err_o  out  1  sticky out-of-range access flag.

Behaviour:
- Reset: FSM=IDLE; d_data_o=0; d_valid_o=0; d_busy_o=0; err_o=0; wait counter=0. RAM contents are not cleared.
- Decode:
  - in_range = (d_addr_i - BASE_ADDR) < DEPTH_WORDS*4, computed as 32-bit unsigned.
  - Word index = (d_addr_i - BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
- Writes:
  - Accepted in any state when d_we_i≠0 and in range.
  - Lane k = RAM[idx][8k+7:8k] ← d_data_i[8k+7:8k] for each set d_we_i[k], at the clock edge.
  - Zero latency; never stalls.
- FSM states: IDLE, WAIT, RESP.
  - IDLE:
    - If d_rd_i≠0 and d_we_i==0: latch word index, lane mask and range bit.
    - Counter ← READ_LAT-1.
    - Next state = RESP if READ_LAT==1, else WAIT.
    - If d_rd_i≠0 and d_we_i≠0 together: the write is performed and the read is not accepted this cycle. The core holds the strobe, so the read starts in the next cycle.
  - WAIT: decrement counter; at 1 go to RESP. Strobes are ignored apart from writes.
  - RESP:
    - d_data_o ← RAM[latched idx] masked per latched lanes (unselected lanes = 0); d_valid_o=1 for exactly this cycle.
    - Next state IDLE.
    - RAM is sampled in RESP, so a write to the same word during WAIT is visible in the returned data.
- Total load latency: READ_LAT+1 edges from the strobe-sampling edge to valid. READ_LAT=1 gives valid in the cycle after acceptance.
- Held strobes:
  - A read strobe still asserted in the IDLE cycle after RESP is treated as a new request.
  - Back-to-back loads therefore have a one-cycle IDLE gap.
- d_data_o holds its last value outside RESP; d_valid_o=0 outside RESP.
- Out of range:
  - Writes are ignored.
  - Reads complete normally with data 0.
  - Either sets err_o, which clears only on reset.
- d_busy_o = (state≠IDLE).
- Reset mid-read: FSM returns to IDLE immediately; the pending read is dropped and no valid pulse occurs; outputs take their reset values.

Optional Feature:
- Macro DMEM_MMIO_CONSOLE_EN.
- When defined:
  - Add ports console_data_o (out, 8) and console_valid_o (out, 1).
  - A write with d_we_i[0]=1 to byte address 32'hFFFF_FFF0 drives console_data_o ← d_data_i[7:0] and pulses console_valid_o for one cycle.
  - That address does not set err_o.
  - A read from it returns 0 without error.
  - Both ports reset to 0.
- When undefined: the ports are absent and 32'hFFFF_FFF0 is treated as an ordinary out-of-range address.

Test Plan:
1. Reset, then write 32'hDEADBEEF to 0x10 with we=4'hF; read 0x10 with rd=4'hF, READ_LAT=1 → d_valid_o pulses 2 edges after the strobe sample, with d_data_o=32'hDEADBEEF.
2. Write 32'h11223344 to 0x20 (we=4'hF); write 32'h000000AA with we=4'b0001; read with rd=4'b0011 → data 32'h000033AA.
3. READ_LAT=3: read 0x20; mid-WAIT write 32'hCAFEF00D with we=4'hF → valid arrives 4 edges after acceptance with data 32'hCAFEF00D; d_busy_o high for 3 cycles.
4. Read from BASE_ADDR+DEPTH_WORDS*4 → valid with data 0 and err_o=1, sticky. A write to the same address leaves RAM unchanged.
5. Assert rst_i during WAIT → no valid pulse; outputs 0; a subsequent read returns the previously written data (RAM retained).
6. With DMEM_MMIO_CONSOLE_EN defined: write 32'h00000041 to 32'hFFFF_FFF0 → console_valid_o pulses once with console_data_o=8'h41, and err_o stays 0.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Data-port bundle between the core (master) and dmem_responder (slave).
// Carries the byte-lane request strobes and the load response.
interface dmem_responder_if;
  logic [31:0] d_addr_i;
  logic [31:0] d_data_i;
  logic [3:0]  d_rd_i;
  logic [3:0]  d_we_i;
  logic [31:0] d_data_o;
  logic        d_valid_o;
  logic        d_busy_o;

  modport master (
    output d_addr_i, d_data_i, d_rd_i, d_we_i,
    input  d_data_o, d_valid_o, d_busy_o
  );

  modport slave (
    input  d_addr_i, d_data_i, d_rd_i, d_we_i,
    output d_data_o, d_valid_o, d_busy_o
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data RAM behind the core's data port.
// Stores are posted and land in the same edge; loads wait READ_LAT cycles
// in a small FSM, then return lane-masked data with a one-cycle valid pulse.
// Optional feature: define DMEM_MMIO_CONSOLE_EN to add a byte-wide console
// register at byte address 32'hFFFF_FFF0.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned READ_LAT    = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  dmem_responder_if.slave bus,
  output logic            err_o
`ifdef DMEM_MMIO_CONSOLE_EN
  ,
  output logic [7:0]      console_data_o,
  output logic            console_valid_o
`endif
);

  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  // Counter only has to hold READ_LAT-1; keep at least one bit.
  localparam int          CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [3:0]         lane_reg, lane_next;
  logic               range_reg, range_next;
  logic               d_valid_reg;
  logic               err_reg;
  logic               rd_accept;

  // Address decode; the subtraction wraps so addresses below BASE_ADDR
  // land far above SPAN and fall out of range.
  logic [31:0]        offset;
  logic               in_range;
  logic [IDX_W-1:0]   idx;
  logic               wr_req;
  logic               rd_req;
  logic               is_console;
  logic               wr_en;
  logic               err_set;

  assign offset   = bus.d_addr_i - BASE_ADDR;
  assign in_range = (offset < SPAN);
  assign idx      = offset[IDX_W+1:2];
  assign wr_req   = |bus.d_we_i;
  assign rd_req   = |bus.d_rd_i;

`ifdef DMEM_MMIO_CONSOLE_EN
  localparam logic [29:0] CONSOLE_WORD = 30'h3FFF_FFFC;  // 32'hFFFF_FFF0 >> 2
  assign is_console = (bus.d_addr_i[31:2] == CONSOLE_WORD);
`else
  assign is_console = 1'b0;
`endif

  // The console address never touches RAM even if the window overlaps it.
  assign wr_en   = wr_req && in_range && !is_console;
  assign err_set = !in_range && !is_console && (wr_req || rd_accept);

  // Next-state logic: a read is taken only from IDLE and only when no write
  // is presented in the same cycle (the core keeps holding the read strobe).
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    lane_next  = lane_reg;
    range_next = range_reg;
    rd_accept  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (rd_req && !wr_req) begin
          rd_accept  = 1'b1;
          idx_next   = idx;
          lane_next  = bus.d_rd_i;
          range_next = in_range && !is_console;
          cnt_next   = CNT_W'(READ_LAT - 1);
          state_next = (READ_LAT == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == CNT_W'(1)) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // FSM state and latched read request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      lane_reg  <= '0;
      range_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      lane_reg  <= lane_next;
      range_reg <= range_next;
    end
  end

  // Valid is registered off RESP so it coincides with the new d_data_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      d_valid_reg <= 1'b0;
    end else begin
      d_valid_reg <= (state_reg == ST_RESP);
    end
  end

  // Sticky out-of-range flag; only reset clears it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_reg <= 1'b0;
    end else if (err_set) begin
      err_reg <= 1'b1;
    end
  end

  // One RAM slice per byte lane, so each lane write is a plain array write.
  // The slice is read in RESP, which makes writes during WAIT visible.
  for (genvar gi = 0; gi < 4; gi++) begin : gen_lane
    logic [7:0] mem [DEPTH_WORDS];
    logic [7:0] byte_reg;

    // Posted byte-lane store.
    always_ff @(posedge clk_i) begin
      if (wr_en && bus.d_we_i[gi]) begin
        mem[idx] <= bus.d_data_i[8*gi +: 8];
      end
    end

    // Load data for this lane; unselected lanes and out-of-range reads give 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        byte_reg <= 8'h00;
      end else if (state_reg == ST_RESP) begin
        byte_reg <= (lane_reg[gi] && range_reg) ? mem[idx_reg] : 8'h00;
      end
    end

    assign bus.d_data_o[8*gi +: 8] = byte_reg;
  end

`ifdef DMEM_MMIO_CONSOLE_EN
  logic [7:0] console_data_reg;
  logic       console_valid_reg;

  // Console register: low byte of a lane-0 store to the console address.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      console_data_reg  <= 8'h00;
      console_valid_reg <= 1'b0;
    end else begin
      console_valid_reg <= is_console && bus.d_we_i[0];
      if (is_console && bus.d_we_i[0]) begin
        console_data_reg <= bus.d_data_i[7:0];
      end
    end
  end

  assign console_data_o  = console_data_reg;
  assign console_valid_o = console_valid_reg;
`endif

  assign bus.d_valid_o = d_valid_reg;
  assign bus.d_busy_o  = (state_reg != ST_IDLE);
  assign err_o         = err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: two instances (READ_LAT=1 at base 0,
// READ_LAT=3 at base 0x1000) share clock and reset. Load data is checked
// by a per-instance scoreboard queue; latency, busy and error flags inline.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  dmem_responder_if bus0();
  dmem_responder_if bus1();

  logic        err_w [2];
  logic [31:0] addr_d [2];
  logic [31:0] wdata_d [2];
  logic [3:0]  rd_d [2];
  logic [3:0]  we_d [2];
  logic [31:0] rdata_w [2];
  logic        valid_w [2];
  logic        busy_w [2];
  logic        err0, err1;

`ifdef DMEM_MMIO_CONSOLE_EN
  logic [7:0] con_data0, con_data1;
  logic       con_valid0, con_valid1;
`endif

  assign bus0.d_addr_i = addr_d[0];
  assign bus0.d_data_i = wdata_d[0];
  assign bus0.d_rd_i   = rd_d[0];
  assign bus0.d_we_i   = we_d[0];
  assign bus1.d_addr_i = addr_d[1];
  assign bus1.d_data_i = wdata_d[1];
  assign bus1.d_rd_i   = rd_d[1];
  assign bus1.d_we_i   = we_d[1];
  assign rdata_w[0] = bus0.d_data_o;
  assign rdata_w[1] = bus1.d_data_o;
  assign valid_w[0] = bus0.d_valid_o;
  assign valid_w[1] = bus1.d_valid_o;
  assign busy_w[0]  = bus0.d_busy_o;
  assign busy_w[1]  = bus1.d_busy_o;
  assign err_w[0]   = err0;
  assign err_w[1]   = err1;

  dmem_responder #(.DEPTH_WORDS(1024), .READ_LAT(1), .BASE_ADDR(32'h0000_0000)) dut0 (
    .clk_i(clk), .rst_i(rst), .bus(bus0.slave), .err_o(err0)
`ifdef DMEM_MMIO_CONSOLE_EN
    , .console_data_o(con_data0), .console_valid_o(con_valid0)
`endif
  );

  dmem_responder #(.DEPTH_WORDS(256), .READ_LAT(3), .BASE_ADDR(32'h0000_1000)) dut1 (
    .clk_i(clk), .rst_i(rst), .bus(bus1.slave), .err_o(err1)
`ifdef DMEM_MMIO_CONSOLE_EN
    , .console_data_o(con_data1), .console_valid_o(con_valid1)
`endif
  );

  // Scoreboards: expected load data, pushed when a read is driven.
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];
  logic [31:0] exp0_v, exp1_v;

  always @(negedge clk) begin
    if (valid_w[0]) begin
      checks++;
      if (exp_q0.size() == 0) begin
        errors++;
        $display("FAIL dut0_unexpected_valid data=%h required no valid pulse", rdata_w[0]);
      end else begin
        exp0_v = exp_q0.pop_front();
        if (rdata_w[0] !== exp0_v) begin
          errors++;
          $display("FAIL dut0_load_data got=%h required=%h", rdata_w[0], exp0_v);
        end else begin
          $display("dut0 load data=%h", rdata_w[0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (valid_w[1]) begin
      checks++;
      if (exp_q1.size() == 0) begin
        errors++;
        $display("FAIL dut1_unexpected_valid data=%h required no valid pulse", rdata_w[1]);
      end else begin
        exp1_v = exp_q1.pop_front();
        if (rdata_w[1] !== exp1_v) begin
          errors++;
          $display("FAIL dut1_load_data got=%h required=%h", rdata_w[1], exp1_v);
        end else begin
          $display("dut1 load data=%h", rdata_w[1]);
        end
      end
    end
  end

  task automatic do_write(input int sel, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] we);
    @(negedge clk);
    addr_d[sel]  = a;
    wdata_d[sel] = d;
    we_d[sel]    = we;
    @(posedge clk);
    @(negedge clk);
    we_d[sel] = 4'h0;
    $display("dut%0d write addr=%h data=%h we=%b", sel, a, d, we);
  endtask

  // Issue one read, optionally with a store to the same address while the
  // read is waiting, and check the valid latency and busy duration.
  task automatic do_read(input int sel, input logic [31:0] a, input logic [3:0] rd,
                         input logic [31:0] exp, input int exp_lat, input bit mw,
                         input logic [31:0] mw_d, input logic [3:0] mw_we);
    int lat = 0;
    int busy_cnt = 0;
    @(negedge clk);
    addr_d[sel] = a;
    rd_d[sel]   = rd;
    if (sel == 0) exp_q0.push_back(exp);
    else          exp_q1.push_back(exp);
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 1) begin
        rd_d[sel] = 4'h0;
        if (mw) begin
          wdata_d[sel] = mw_d;
          we_d[sel]    = mw_we;
        end
      end
      if (n == 2) we_d[sel] = 4'h0;
      if (busy_w[sel]) busy_cnt++;
      if (valid_w[sel]) lat = n;
    end
    $display("dut%0d read addr=%h rd=%b latency=%0d", sel, a, rd, lat);
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL dut%0d_read_latency addr=%h got=%0d required=%0d (0 = timeout)", sel, a, lat, exp_lat);
    end
    checks++;
    if (busy_cnt != exp_lat - 1) begin
      errors++;
      $display("FAIL dut%0d_busy_cycles got=%0d required=%0d", sel, busy_cnt, exp_lat - 1);
    end
  endtask

  task automatic check_err(input int sel, input logic exp, input string tag);
    checks++;
    if (err_w[sel] !== exp) begin
      errors++;
      $display("FAIL %s dut%0d err_o got=%b required=%b", tag, sel, err_w[sel], exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (rdata_w[s] !== 32'h0 || valid_w[s] !== 1'b0 || busy_w[s] !== 1'b0 || err_w[s] !== 1'b0) begin
        errors++;
        $display("FAIL %s dut%0d data=%h valid=%b busy=%b err=%b required all zero",
                 tag, s, rdata_w[s], valid_w[s], busy_w[s], err_w[s]);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    check_idle_outputs("reset_state");
    rst = 1'b0;
    $display("reset released");
  endtask

  task automatic test_basic_read();
    do_write(0, 32'h10, 32'hDEADBEEF, 4'hF);
    do_read(0, 32'h10, 4'hF, 32'hDEADBEEF, 2, 1'b0, 32'h0, 4'h0);
  endtask

  task automatic test_byte_lanes();
    do_write(0, 32'h20, 32'h11223344, 4'hF);
    do_write(0, 32'h20, 32'h000000AA, 4'b0001);
    do_read(0, 32'h20, 4'b0011, 32'h000033AA, 2, 1'b0, 32'h0, 4'h0);
    do_read(0, 32'h22, 4'b1100, 32'h11220000, 2, 1'b0, 32'h0, 4'h0);
    check_err(0, 1'b0, "in_range_no_err");
  endtask

  task automatic test_wait_states();
    do_write(1, 32'h1020, 32'h11223344, 4'hF);
    do_read(1, 32'h1020, 4'hF, 32'hCAFEF00D, 4, 1'b1, 32'hCAFEF00D, 4'hF);
    do_write(1, 32'h13FC, 32'h0BADCAFE, 4'hF);
    do_read(1, 32'h13FC, 4'hF, 32'h0BADCAFE, 4, 1'b0, 32'h0, 4'h0);
    check_err(1, 1'b0, "last_word_no_err");
  endtask

  task automatic test_out_of_range();
    do_write(0, 32'h0, 32'h01020304, 4'hF);
    do_read(0, 32'h1000, 4'hF, 32'h0, 2, 1'b0, 32'h0, 4'h0);
    check_err(0, 1'b1, "oor_read_err");
    do_write(0, 32'h1000, 32'hFFFFFFFF, 4'hF);
    do_read(0, 32'h0, 4'hF, 32'h01020304, 2, 1'b0, 32'h0, 4'h0);
    check_err(0, 1'b1, "err_sticky");
    do_read(1, 32'h0FFC, 4'hF, 32'h0, 4, 1'b0, 32'h0, 4'h0);
    check_err(1, 1'b1, "below_base_err");
  endtask

  task automatic test_back_to_back();
    int vmask = 0;
    do_write(0, 32'h40, 32'h76543210, 4'hF);
    @(negedge clk);
    addr_d[0] = 32'h40;
    rd_d[0]   = 4'hF;
    exp_q0.push_back(32'h76543210);
    exp_q0.push_back(32'h76543210);
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 4) rd_d[0] = 4'h0;
      if (valid_w[0]) vmask |= (1 << (n - 1));
    end
    $display("dut0 held read addr=40 valid_mask=%b", vmask[5:0]);
    checks++;
    if (vmask != 6'b001010) begin
      errors++;
      $display("FAIL held_read_valid_pattern got=%b required=%b", vmask[5:0], 6'b001010);
    end
  endtask

  task automatic test_read_write_collision();
    int lat = 0;
    @(negedge clk);
    addr_d[0]  = 32'h50;
    wdata_d[0] = 32'h5A5A1234;
    we_d[0]    = 4'hF;
    rd_d[0]    = 4'hF;
    exp_q0.push_back(32'h5A5A1234);
    for (int n = 1; n <= 10 && lat == 0; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 1) begin
        we_d[0] = 4'h0;
        checks++;
        if (busy_w[0] !== 1'b0) begin
          errors++;
          $display("FAIL collision_read_deferred busy=%b required=0", busy_w[0]);
        end
      end
      if (n == 2) rd_d[0] = 4'h0;
      if (valid_w[0]) lat = n;
    end
    $display("dut0 read+write addr=50 latency=%0d", lat);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL collision_latency got=%0d required=3 (0 = timeout)", lat);
    end
  endtask

  task automatic test_reset_mid_read();
    do_write(1, 32'h1010, 32'hA5A55A5A, 4'hF);
    @(negedge clk);
    addr_d[1] = 32'h1010;
    rd_d[1]   = 4'hF;
    @(posedge clk);
    @(negedge clk);
    rd_d[1] = 4'h0;
    checks++;
    if (busy_w[1] !== 1'b1) begin
      errors++;
      $display("FAIL mid_read_busy got=%b required=1", busy_w[1]);
    end
    rst = 1'b1;
    #1;
    check_idle_outputs("reset_mid_read");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    $display("dut1 reset during WAIT, read dropped");
    do_read(1, 32'h1010, 4'hF, 32'hA5A55A5A, 4, 1'b0, 32'h0, 4'h0);
    check_err(0, 1'b0, "err_cleared_by_reset");
  endtask

`ifdef DMEM_MMIO_CONSOLE_EN
  task automatic test_console();
    @(negedge clk);
    addr_d[0]  = 32'hFFFF_FFF0;
    wdata_d[0] = 32'h00000041;
    we_d[0]    = 4'hF;
    @(posedge clk);
    @(negedge clk);
    we_d[0] = 4'h0;
    checks++;
    if (con_valid0 !== 1'b1 || con_data0 !== 8'h41) begin
      errors++;
      $display("FAIL console_write valid=%b data=%h required valid=1 data=41", con_valid0, con_data0);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (con_valid0 !== 1'b0) begin
      errors++;
      $display("FAIL console_pulse_width valid=%b required=0", con_valid0);
    end
    $display("dut0 console write data=41");
    check_err(0, 1'b0, "console_write_no_err");
    do_read(0, 32'hFFFF_FFF0, 4'hF, 32'h0, 2, 1'b0, 32'h0, 4'h0);
    check_err(0, 1'b0, "console_read_no_err");
  endtask
`else
  task automatic test_console();
    do_write(0, 32'hFFFF_FFF0, 32'h00000041, 4'b0001);
    check_err(0, 1'b1, "console_addr_is_oor");
  endtask
`endif

  initial begin
    for (int s = 0; s < 2; s++) begin
      addr_d[s]  = 32'h0;
      wdata_d[s] = 32'h0;
      rd_d[s]    = 4'h0;
      we_d[s]    = 4'h0;
    end
    repeat (3) @(posedge clk);
    test_reset();
    test_basic_read();
    test_byte_lanes();
    test_wait_states();
    test_back_to_back();
    test_read_write_collision();
    test_out_of_range();
    test_reset_mid_read();
    test_console();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending dut0=%0d dut1=%0d required 0", exp_q0.size(), exp_q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
